sfifo_reader: RTL and testbench



---
 rtl/sfifo_reader.sv | 151 +++++++++++++++
 tb/tb_sfifo_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfifo_reader.sv
// ---------------------------------------------------------------------------
// sfifo_reader
//
// Drains the first-word-fall-through read port of a synchronous FIFO and
// presents the words as a valid/ready stream framed into bursts: o_last marks
// every L-th word, where L comes from i_burst_len at the start of each burst.
// A one-word skid register sits behind the output register. Because of it, the
// FIFO read strobe depends only on registered state and the FIFO flag, never
// on i_ready.
//
// Optional build macro:
//   SFIFO_READER_STATS_EN  adds o_xfers / o_stalls event counters.
//
// Parameters:
//   BW       data width; must match the FIFO's BW
//   LGBURST  log2 of the maximum burst length (max burst = 2^LGBURST words)
//
// Ports:
//   i_clk         system clock
//   i_reset       asynchronous, active-high reset
//   i_fifo_empty  FIFO empty flag; i_fifo_data is valid whenever low
//   i_fifo_data   FIFO head word (fall-through)
//   o_fifo_rd     FIFO read strobe; pops the head word this cycle
//   i_burst_len   requested burst length, sampled at burst start
//   o_valid       stream word valid
//   i_ready       downstream accepts word
//   o_data        stream word
//   o_last        final word of the current burst
//   o_count       words loaded into the pipeline for the current burst
//   o_busy        o_valid, or skid occupied, or o_count != 0
//   o_xfers       (SFIFO_READER_STATS_EN) handshake count, wraps at 2^32
//   o_stalls      (SFIFO_READER_STATS_EN) o_valid && !i_ready cycles, wraps
// ---------------------------------------------------------------------------
module sfifo_reader #(
  parameter int BW      = 8,
  parameter int LGBURST = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_fifo_empty,
  input  logic [BW-1:0]      i_fifo_data,
  output logic               o_fifo_rd,
  input  logic [LGBURST:0]   i_burst_len,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [BW-1:0]      o_data,
  output logic               o_last,
  output logic [LGBURST:0]   o_count,
  output logic               o_busy
`ifdef SFIFO_READER_STATS_EN
  ,
  output logic [31:0]        o_xfers,
  output logic [31:0]        o_stalls
`endif
);

  localparam int CW = LGBURST + 1;
  localparam logic [CW-1:0] ONE     = {{LGBURST{1'b0}}, 1'b1};
  localparam logic [CW-1:0] MAX_LEN = {1'b1, {LGBURST{1'b0}}};

  // A zero request means single-word bursts; requests above the maximum
  // saturate to the maximum burst.
  function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] req);
    if (req == '0)
      return ONE;
    else if (req > MAX_LEN)
      return MAX_LEN;
    else
      return req;
  endfunction

  logic              handshake;
  logic              skid_valid;
  logic [BW-1:0]     skid_data;
  logic              skid_last;
  logic [CW-1:0]     burst_len_q;
  logic [CW-1:0]     cur_len;
  logic              word_last;

  // The read strobe must not see i_ready: a word is popped only when the skid
  // is free, so there is always room for it whatever the consumer does.
  assign o_fifo_rd = !i_fifo_empty && !skid_valid;
  assign handshake = o_valid && i_ready;
  assign o_busy    = o_valid || skid_valid || (o_count != '0);

  // The first word of a burst uses the freshly clamped request; later words
  // use the length latched when that first word loaded.
  assign cur_len   = (o_count == '0) ? clamp_len(i_burst_len) : burst_len_q;
  assign word_last = (o_count == (cur_len - ONE));

  // ---- stage boundary: FIFO head -> output register / skid register ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_last     <= 1'b0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
    end else if (o_fifo_rd) begin
      // A load implies the skid is empty; the word goes straight to the
      // output unless the output is holding a stalled word.
      if (!o_valid || i_ready) begin
        o_valid <= 1'b1;
        o_data  <= i_fifo_data;
        o_last  <= word_last;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= i_fifo_data;
        skid_last  <= word_last;
      end
    end else if (handshake) begin
      if (skid_valid) begin
        o_data     <= skid_data;
        o_last     <= skid_last;
        skid_valid <= 1'b0;
      end else begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end
    end
  end

  // ---- stage boundary: burst framing counter, advanced per loaded word ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_count     <= '0;
      burst_len_q <= ONE;
    end else if (o_fifo_rd) begin
      if (o_count == '0)
        burst_len_q <= cur_len;
      o_count <= word_last ? '0 : (o_count + ONE);
    end
  end

`ifdef SFIFO_READER_STATS_EN
  // ---- stage boundary: event counters ----
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_xfers  <= '0;
      o_stalls <= '0;
    end else begin
      if (handshake)
        o_xfers <= o_xfers + 32'd1;
      if (o_valid && !i_ready)
        o_stalls <= o_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sfifo_reader.sv
// ---------------------------------------------------------------------------
// Testbench for sfifo_reader (BW=8, LGBURST=4). A queue stands in for the FIFO
// contents; popped words are queued as the expected output order, and burst
// framing is predicted by counting delivered words against the requested burst
// length.
// ---------------------------------------------------------------------------
module tb_sfifo_reader;
  localparam int BW      = 8;
  localparam int LGBURST = 4;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_fifo_empty;
  logic [BW-1:0]   i_fifo_data;
  logic            o_fifo_rd;
  logic [LGBURST:0] i_burst_len;
  logic            o_valid;
  logic            i_ready;
  logic [BW-1:0]   o_data;
  logic            o_last;
  logic [LGBURST:0] o_count;
  logic            o_busy;
`ifdef SFIFO_READER_STATS_EN
  logic [31:0]     o_xfers;
  logic [31:0]     o_stalls;
`endif

  sfifo_reader #(.BW(BW), .LGBURST(LGBURST)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_fifo_empty(i_fifo_empty),
    .i_fifo_data (i_fifo_data),
    .o_fifo_rd   (o_fifo_rd),
    .i_burst_len (i_burst_len),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_data      (o_data),
    .o_last      (o_last),
    .o_count     (o_count),
    .o_busy      (o_busy)
`ifdef SFIFO_READER_STATS_EN
    ,
    .o_xfers     (o_xfers),
    .o_stalls    (o_stalls)
`endif
  );

  always #5 i_clk = ~i_clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] src_q[$];   // FIFO contents
  logic [7:0] fly_q[$];   // popped from FIFO, not yet delivered
  int mdl_L, mdl_next_L, mdl_pos;
  int hs_total, rd_total, last_total;
  int exp_xfers, exp_stalls;
  logic prev_stall;
  logic [7:0] prev_data;
  logic prev_last;
  logic s_valid, s_last, s_rd, s_busy;
  logic [7:0] s_data;
  logic [4:0] s_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int r);
    if (r == 0) return 1;
    if (r > 16) return 16;
    return r;
  endfunction

  // One clock: drive inputs, sample outputs, update the scoreboard, advance.
  task automatic cycle(input logic rdy, input logic gate);
    logic [7:0] exp_data;
    logic       exp_last;
    i_ready      = rdy;
    i_fifo_empty = (src_q.size() == 0) || gate;
    i_fifo_data  = (src_q.size() != 0) ? src_q[0] : 8'h00;
    #1;
    s_valid = o_valid;
    s_data  = o_data;
    s_last  = o_last;
    s_rd    = o_fifo_rd;
    s_count = o_count;
    s_busy  = o_busy;
    if (s_rd) begin
      check("rd_while_empty", 32'(i_fifo_empty), 32'd0);
      rd_total++;
      if (src_q.size() != 0) fly_q.push_back(src_q.pop_front());
    end
    if (prev_stall) begin
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_data", 32'(s_data), 32'(prev_data));
      check("stall_last", 32'(s_last), 32'(prev_last));
    end
    if (s_valid && rdy) begin
      if (fly_q.size() != 0) exp_data = fly_q.pop_front();
      else                   exp_data = ~s_data;
      exp_last = (mdl_pos == mdl_L - 1);
      check("order_data", 32'(s_data), 32'(exp_data));
      check("burst_last", 32'(s_last), 32'(exp_last));
      if (exp_last) begin
        mdl_pos = 0;
        mdl_L   = mdl_next_L;
        last_total++;
      end else begin
        mdl_pos++;
      end
      hs_total++;
      exp_xfers++;
    end
    prev_stall = s_valid && !rdy;
    prev_data  = s_data;
    prev_last  = s_last;
    if (prev_stall) exp_stalls++;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic do_reset();
    i_reset      = 1'b1;
    i_ready      = 1'b0;
    i_fifo_empty = 1'b1;
    src_q.delete();
    fly_q.delete();
    mdl_L      = clamp(int'(i_burst_len));
    mdl_next_L = mdl_L;
    mdl_pos    = 0;
    prev_stall = 1'b0;
    exp_xfers  = 0;
    exp_stalls = 0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  initial begin
    int r0, h0, l0, cyc;
    i_reset      = 1'b1;
    i_ready      = 1'b0;
    i_fifo_empty = 1'b1;
    i_fifo_data  = '0;
    i_burst_len  = 5'd4;
    hs_total = 0; rd_total = 0; last_total = 0;
    @(negedge i_clk);
    do_reset();

    // Reset state
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
`ifdef SFIFO_READER_STATS_EN
    check("rst_xfers", o_xfers, 32'd0);
    check("rst_stalls", o_stalls, 32'd0);
`endif

    // Streaming 0x10..0x17 with bursts of 4 and the consumer always ready
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h10 + i));
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b0);
      check("t1_rd", 32'(s_rd), 32'(c < 8));
      check("t1_valid", 32'(s_valid), 32'(c >= 1 && c <= 8));
      if (c >= 1 && c <= 8) begin
        check("t1_data", 32'(s_data), 32'(8'h10 + c - 1));
        check("t1_last", 32'(s_last), 32'(c % 4 == 0));
        check("t1_count", 32'(s_count), 32'(c % 4));
      end
    end

    // Consumer stalled for 5 cycles: only output + skid fill
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'hA0 + i));
    r0 = rd_total;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b0);
      if (c >= 1) begin
        check("t2_valid", 32'(s_valid), 32'd1);
        check("t2_hold", 32'(s_data), 32'hA0);
      end
    end
    check("t2_rd_pulses", 32'(rd_total - r0), 32'd2);
    h0 = hs_total;
    for (int c = 0; c < 6; c++) cycle(1'b1, 1'b0);
    check("t2_delivered", 32'(hs_total - h0), 32'd4);
    check("t2_rd_total", 32'(rd_total - r0), 32'd4);

    // Burst length 0 -> every word last
    i_burst_len = 5'd0;
    do_reset();
    for (int i = 0; i < 6; i++) src_q.push_back(8'($urandom));
    l0 = last_total;
    for (int c = 0; c < 9; c++) begin
      cycle(1'b1, 1'b0);
      check("t3_count0", 32'(s_count), 32'd0);
    end
    check("t3_lasts", 32'(last_total - l0), 32'd6);

    // Burst length 31 -> clamped to 16
    i_burst_len = 5'd31;
    do_reset();
    for (int i = 0; i < 32; i++) src_q.push_back(8'($urandom));
    l0 = last_total;
    h0 = hs_total;
    for (int c = 0; c < 35; c++) cycle(1'b1, 1'b0);
    check("t3_words16", 32'(hs_total - h0), 32'd32);
    check("t3_lasts16", 32'(last_total - l0), 32'd2);

    // Burst of 3 with the FIFO running dry after 2 words
    i_burst_len = 5'd3;
    do_reset();
    src_q.push_back(8'h31);
    src_q.push_back(8'h32);
    l0 = last_total;
    for (int c = 0; c < 3; c++) cycle(1'b1, 1'b0);
    i_burst_len = 5'd7;   // must not affect the burst in progress
    mdl_next_L  = 7;
    for (int c = 0; c < 10; c++) begin
      cycle(1'b1, 1'b0);
      check("t4_gap_count", 32'(s_count), 32'd2);
      check("t4_gap_busy", 32'(s_busy), 32'd1);
      check("t4_gap_valid", 32'(s_valid), 32'd0);
    end
    src_q.push_back(8'h33);
    src_q.push_back(8'h34);
    for (int c = 0; c < 4; c++) cycle(1'b1, 1'b0);
    check("t4_lasts", 32'(last_total - l0), 32'd1);
    check("t4_newburst_count", 32'(s_count), 32'd1);

    // Random ready / FIFO availability, 10000 words
    i_burst_len = 5'($urandom_range(0, 20));
    do_reset();
    h0  = hs_total;
    cyc = 0;
    while ((hs_total - h0) < 10000 && cyc < 60000) begin
      if (src_q.size() < 3) src_q.push_back(8'($urandom));
      cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      cyc++;
    end
    check("rand_words", 32'(hs_total - h0), 32'd10000);
`ifdef SFIFO_READER_STATS_EN
    check("rand_xfers", o_xfers, 32'(exp_xfers));
    check("rand_stalls", o_stalls, 32'(exp_stalls));
`endif

    // Asynchronous reset mid-burst with the skid full
    i_burst_len = 5'd8;
    do_reset();
    for (int i = 0; i < 4; i++) src_q.push_back(8'(8'h50 + i));
    for (int c = 0; c < 3; c++) cycle(1'b0, 1'b0);
    check("t6_pre_count", 32'(o_count), 32'd2);
    check("t6_pre_valid", 32'(o_valid), 32'd1);
    #2;
    i_reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(o_valid), 32'd0);
    check("t6_async_last", 32'(o_last), 32'd0);
    check("t6_async_count", 32'(o_count), 32'd0);
    check("t6_async_busy", 32'(o_busy), 32'd0);
    check("t6_async_data", 32'(o_data), 32'd0);
`ifdef SFIFO_READER_STATS_EN
    check("t6_async_xfers", o_xfers, 32'd0);
    check("t6_async_stalls", o_stalls, 32'd0);
`endif
    @(negedge i_clk);
    do_reset();
    for (int i = 0; i < 8; i++) src_q.push_back(8'(8'h60 + i));
    l0 = last_total;
    h0 = hs_total;
    for (int c = 0; c < 10; c++) cycle(1'b1, 1'b0);
    check("t6_after_words", 32'(hs_total - h0), 32'd8);
    check("t6_after_lasts", 32'(last_total - l0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
